// File: rtl/opm_seq_pkg.sv
// Shared types and default timings for the OPM register-write sequencer.
package opm_seq_pkg;

   localparam int DEF_SETUP_CYC  = 15;
   localparam int DEF_PULSE_CYC  = 20;
   localparam int DEF_HOLD_CYC   = 15;
   localparam int DEF_GAP_CYC    = 200;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int CNT_W          = 12;

   typedef enum logic [2:0] {
      IDLE,
      A_SETUP,
      A_PULSE,
      A_HOLD,
      D_SETUP,
      D_PULSE,
      D_HOLD,
      GAP
   } opm_state_t;

endpackage

// File: rtl/opm_write_sequencer_if.sv
// Command handshake and OPM bus signals of the write sequencer.
interface opm_write_sequencer_if;
   logic       i_CMD_VALID;
   logic [7:0] i_CMD_ADDR;
   logic [7:0] i_CMD_DATA;
   logic       o_CMD_READY;
   logic       o_CS_n;
   logic       o_WR_n;
   logic       o_A0;
   logic [7:0] o_D;
   logic       o_BUSY;

   modport master (
      output i_CMD_VALID, i_CMD_ADDR, i_CMD_DATA,
      input  o_CMD_READY, o_CS_n, o_WR_n, o_A0, o_D, o_BUSY
   );

   modport slave (
      input  i_CMD_VALID, i_CMD_ADDR, i_CMD_DATA,
      output o_CMD_READY, o_CS_n, o_WR_n, o_A0, o_D, o_BUSY
   );
endinterface

// File: rtl/opm_cmd_fifo.sv
// Command queue: power-of-two depth, extra pointer bit separates full from empty.
module opm_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic             i_EMUCLK,
   input  logic             i_RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // a pop in the same cycle frees the slot, so a push into a full queue still lands
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_EMUCLK) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/opm_write_sequencer.sv
// Queues OPM register writes and plays each out as an address strobe, a data strobe and a gap.
//   state   | meaning
//   IDLE    | waiting for a queued command; pops head when one is present
//   A_SETUP | CS_n low, A0=0, address on D before the strobe
//   A_PULSE | WR_n low with the address
//   A_HOLD  | strobes released, address held
//   D_SETUP | CS_n low, A0=1, data on D before the strobe
//   D_PULSE | WR_n low with the data
//   D_HOLD  | strobes released, data held
//   GAP     | chip recovery time before the next command
module opm_write_sequencer
   import opm_seq_pkg::*;
#(
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int PULSE_CYC  = DEF_PULSE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int GAP_CYC    = DEF_GAP_CYC,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  i_EMUCLK,
   input  logic                  i_RST,
   opm_write_sequencer_if.slave  bus
);
   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] LD_GAP   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

   opm_state_t       state;
   opm_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             push;
   logic             ready;
   logic [15:0]      head;
   logic [7:0]       cur_addr;
   logic [7:0]       cur_data;
   logic             cs_q;
   logic             wr_q;
   logic             a0_q;
   logic [7:0]       d_q;

   assign pop             = (state == IDLE) && !fifo_empty;
   assign ready           = !fifo_full || pop;
   assign push            = bus.i_CMD_VALID && ready;
   assign bus.o_CMD_READY = ready;
   assign bus.o_BUSY      = (state != IDLE) || !fifo_empty;
   assign bus.o_CS_n      = cs_q;
   assign bus.o_WR_n      = wr_q;
   assign bus.o_A0        = a0_q;
   assign bus.o_D         = d_q;

   opm_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .i_EMUCLK (i_EMUCLK),
      .i_RST    (i_RST),
      .push     (push),
      .pop      (pop),
      .wdata    ({bus.i_CMD_ADDR, bus.i_CMD_DATA}),
      .rdata    (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         state    <= IDLE;
         cnt      <= '0;
         cur_addr <= 8'h00;
         cur_data <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (pop) begin
            cur_addr <= head[15:8];
            cur_data <= head[7:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nxt = A_SETUP;
               cnt_nxt   = LD_SETUP;
            end
         end
         A_SETUP: if (cnt == '0) begin state_nxt = A_PULSE; cnt_nxt = LD_PULSE; end
         A_PULSE: if (cnt == '0) begin state_nxt = A_HOLD;  cnt_nxt = LD_HOLD;  end
         A_HOLD:  if (cnt == '0) begin state_nxt = D_SETUP; cnt_nxt = LD_SETUP; end
         D_SETUP: if (cnt == '0) begin state_nxt = D_PULSE; cnt_nxt = LD_PULSE; end
         D_PULSE: if (cnt == '0) begin state_nxt = D_HOLD;  cnt_nxt = LD_HOLD;  end
         D_HOLD: begin
            if (cnt == '0) begin
               state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
               cnt_nxt   = LD_GAP;
            end
         end
         GAP:     if (cnt == '0) state_nxt = IDLE;
         default: begin state_nxt = IDLE; cnt_nxt = '0; end
      endcase
   end

   // Strobes trail the state by one cycle; A0/D only move together with a CS_n fall.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         cs_q <= 1'b1;
         wr_q <= 1'b1;
         a0_q <= 1'b0;
         d_q  <= 8'h00;
      end else begin
         cs_q <= !(state inside {A_SETUP, A_PULSE, D_SETUP, D_PULSE});
         wr_q <= !(state inside {A_PULSE, D_PULSE});
         if (state inside {A_SETUP, A_PULSE, A_HOLD}) begin
            a0_q <= 1'b0;
            d_q  <= cur_addr;
         end else if (state inside {D_SETUP, D_PULSE, D_HOLD}) begin
            a0_q <= 1'b1;
            d_q  <= cur_data;
         end
      end
   end
endmodule

// File: tb/tb_opm_write_sequencer.sv
// Self-checking bench: two sequencer instances (default timing, and short timing with no gap).
module tb_opm_write_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   opm_write_sequencer_if ifc0 ();
   opm_write_sequencer_if ifc1 ();

   opm_write_sequencer #(
      .SETUP_CYC (15), .PULSE_CYC (20), .HOLD_CYC (15), .GAP_CYC (200), .FIFO_DEPTH (8)
   ) u_dut0 (
      .i_EMUCLK (clk),
      .i_RST    (rst),
      .bus      (ifc0)
   );

   opm_write_sequencer #(
      .SETUP_CYC (2), .PULSE_CYC (3), .HOLD_CYC (2), .GAP_CYC (0), .FIFO_DEPTH (4)
   ) u_dut1 (
      .i_EMUCLK (clk),
      .i_RST    (rst),
      .bus      (ifc1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: a command queue with push edges, plus the start edge of each
   // instance's current and previous transfer; bus waveform is derived from offsets.
   typedef struct {
      int         inst;
      int         p;
      logic [7:0] a;
      logic [7:0] d;
   } cmd_t;

   cmd_t       q[$];
   int         cyc;
   int         PS [2] = '{15, 2};
   int         PP [2] = '{20, 3};
   int         PH [2] = '{15, 2};
   int         PG [2] = '{200, 0};
   int         DEP[2] = '{8, 4};
   int         free_e[2];
   bit         cur_v[2], prv_v[2];
   int         cur_s[2], prv_s[2];
   logic [7:0] cur_a[2], cur_d[2], prv_a[2], prv_d[2];

   function automatic int q_count(int i);
      int n = 0;
      foreach (q[j]) if (q[j].inst == i) n++;
      return n;
   endfunction

   function automatic int q_head(int i);
      foreach (q[j]) if (q[j].inst == i) return j;
      return -1;
   endfunction

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 2; i++) begin
         free_e[i] = 0;
         cur_v[i]  = 0;
         prv_v[i]  = 0;
      end
   endtask

   task automatic exp_bus(input int i, input int l, output logic cs, output logic wr,
                          output logic a0, output logic [7:0] d);
      bit v = 0;
      int s = 0, k, t;
      logic [7:0] aa = 0, dd = 0;
      cs = 1; wr = 1; a0 = 0; d = 8'h00;
      if (cur_v[i] && cur_s[i] <= l) begin
         v = 1; s = cur_s[i]; aa = cur_a[i]; dd = cur_d[i];
      end else if (prv_v[i] && prv_s[i] <= l) begin
         v = 1; s = prv_s[i]; aa = prv_a[i]; dd = prv_d[i];
      end
      if (v) begin
         k = l - s;
         t = PS[i] + PP[i] + PH[i];
         if (k < PS[i])                    begin cs = 0; wr = 1; a0 = 0; d = aa; end
         else if (k < PS[i] + PP[i])       begin cs = 0; wr = 0; a0 = 0; d = aa; end
         else if (k < t)                   begin cs = 1; wr = 1; a0 = 0; d = aa; end
         else if (k < t + PS[i])           begin cs = 0; wr = 1; a0 = 1; d = dd; end
         else if (k < t + PS[i] + PP[i])   begin cs = 0; wr = 0; a0 = 1; d = dd; end
         else                              begin cs = 1; wr = 1; a0 = 1; d = dd; end
      end
   endtask

   task automatic get_out(input int i, output logic cs, output logic wr, output logic a0,
                          output logic [7:0] d, output logic rdy, output logic bsy);
      if (i == 0) begin
         cs = ifc0.o_CS_n; wr = ifc0.o_WR_n; a0 = ifc0.o_A0; d = ifc0.o_D;
         rdy = ifc0.o_CMD_READY; bsy = ifc0.o_BUSY;
      end else begin
         cs = ifc1.o_CS_n; wr = ifc1.o_WR_n; a0 = ifc1.o_A0; d = ifc1.o_D;
         rdy = ifc1.o_CMD_READY; bsy = ifc1.o_BUSY;
      end
   endtask

   task automatic check_reset_outputs(string tag);
      logic cs, wr, a0, rdy, bsy;
      logic [7:0] d;
      for (int i = 0; i < 2; i++) begin
         get_out(i, cs, wr, a0, d, rdy, bsy);
         chk($sformatf("%s_cs_n%0d", tag, i), cs, 1);
         chk($sformatf("%s_wr_n%0d", tag, i), wr, 1);
         chk($sformatf("%s_a0_%0d", tag, i), a0, 0);
         chk($sformatf("%s_d_%0d", tag, i), d, 0);
         chk($sformatf("%s_busy%0d", tag, i), bsy, 0);
         chk($sformatf("%s_ready%0d", tag, i), rdy, 1);
      end
   endtask

   // One clock: compare outputs against the model, drive one instance, advance the model.
   task automatic do_cycle(input int act, input bit v, input logic [7:0] a, input logic [7:0] dd,
                           input bit nowait, output bit acc);
      bit pop_now[2];
      bit rdy_m[2];
      int hd;
      logic cs, wr, a0, rdy, bsy, ecs, ewr, ea0;
      logic [7:0] d, ed;
      if (!nowait) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         exp_bus(i, cyc - 1, ecs, ewr, ea0, ed);
         get_out(i, cs, wr, a0, d, rdy, bsy);
         hd = q_head(i);
         pop_now[i] = (hd >= 0) && (q[hd].p < cyc) && (cyc >= free_e[i]);
         rdy_m[i]   = (q_count(i) < DEP[i]) || pop_now[i];
         chk($sformatf("cs_n%0d@%0d", i, cyc), cs, ecs);
         chk($sformatf("wr_n%0d@%0d", i, cyc), wr, ewr);
         chk($sformatf("a0_%0d@%0d", i, cyc), a0, ea0);
         chk($sformatf("d_%0d@%0d", i, cyc), d, ed);
         chk($sformatf("ready%0d@%0d", i, cyc), rdy, rdy_m[i]);
         chk($sformatf("busy%0d@%0d", i, cyc), bsy, (hd >= 0) || (cyc < free_e[i]));
      end
      ifc0.i_CMD_VALID = (act == 0) && v;
      ifc1.i_CMD_VALID = (act == 1) && v;
      ifc0.i_CMD_ADDR = a; ifc0.i_CMD_DATA = dd;
      ifc1.i_CMD_ADDR = a; ifc1.i_CMD_DATA = dd;
      acc = v && rdy_m[act];
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (pop_now[i]) begin
            hd = q_head(i);
            prv_v[i] = cur_v[i]; prv_s[i] = cur_s[i]; prv_a[i] = cur_a[i]; prv_d[i] = cur_d[i];
            cur_v[i] = 1; cur_s[i] = cyc + 1; cur_a[i] = q[hd].a; cur_d[i] = q[hd].d;
            free_e[i] = cyc + 1 + 2 * (PS[i] + PP[i] + PH[i]) + PG[i];
            q.delete(hd);
         end
      end
      if (acc) q.push_back('{act, cyc, a, dd});
      cyc++;
   endtask

   task automatic idle_cycle();
      bit acc;
      do_cycle(0, 0, 8'h00, 8'h00, 0, acc);
   endtask

   task automatic drain(int i, int bound, string tag);
      int n = 0;
      while ((q_count(i) > 0 || cyc < free_e[i] + 3) && n < bound) begin
         idle_cycle();
         n++;
      end
      chk(tag, (n < bound), 1);
   endtask

   task automatic push_until_accepted(int i, logic [7:0] a, logic [7:0] d, string tag);
      bit acc = 0;
      int n = 0;
      while (!acc && n < 1000) begin
         do_cycle(i, 1, a, d, 0, acc);
         n++;
      end
      chk(tag, acc, 1);
   endtask

   // Bus protocol watch on both instances, sampled mid-cycle.
   logic       p_cs[2], p_wr[2], p_a0[2];
   logic [7:0] p_d[2];
   always @(negedge clk) begin
      logic cs, wr, a0, rdy, bsy;
      logic [7:0] d;
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            get_out(i, cs, wr, a0, d, rdy, bsy);
            if (!wr) chk($sformatf("proto_wr_cs%0d", i), cs, 0);
            if (!wr && !p_wr[i]) chk($sformatf("proto_stable%0d", i), {a0, d}, {p_a0[i], p_d[i]});
            if ({a0, d} != {p_a0[i], p_d[i]})
               chk($sformatf("proto_change%0d", i), (cs || p_cs[i]), 1);
            p_cs[i] = cs; p_wr[i] = wr; p_a0[i] = a0; p_d[i] = d;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            p_cs[i] = 1; p_wr[i] = 1; p_a0[i] = 0; p_d[i] = 8'h00;
         end
      end
   end

   initial begin
      bit acc;
      int n;
      cyc = 0;
      model_reset();
      ifc0.i_CMD_VALID = 0; ifc0.i_CMD_ADDR = 0; ifc0.i_CMD_DATA = 0;
      ifc1.i_CMD_VALID = 0; ifc1.i_CMD_ADDR = 0; ifc1.i_CMD_DATA = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_init");
      #1 rst = 0;

      // single write at default timing, accepted on the first edge after reset
      #1 do_cycle(0, 1, 8'h18, 8'hFF, 1, acc);
      chk("first_push_acc", acc, 1);
      drain(0, 600, "drain_single");

      // ten back-to-back commands into depth 8; the last waits for a pop while full
      for (int k = 0; k < 10; k++)
         push_until_accepted(0, 8'(8'h20 + k), 8'($urandom), $sformatf("burst_acc%0d", k));
      drain(0, 4000, "drain_burst");

      // random traffic on the zero-gap instance
      for (int k = 0; k < 60; k++)
         do_cycle(1, ($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 0, acc);
      for (int k = 0; k < 6; k++)
         push_until_accepted(1, 8'($urandom), 8'($urandom), $sformatf("fill_acc%0d", k));
      drain(1, 1000, "drain_rand");

      // reset in the middle of the data strobe
      do_cycle(1, 1, 8'hA5, 8'h5A, 0, acc);
      n = 0;
      while (!(cur_v[1] && (cyc - 1 - cur_s[1]) == (PS[1] + PP[1] + PH[1] + PS[1] + 1)) && n < 50) begin
         idle_cycle();
         n++;
      end
      chk("reach_dpulse", (n < 50), 1);
      @(negedge clk);
      chk("pre_rst_wr_n", ifc1.o_WR_n, 0);
      chk("pre_rst_a0", ifc1.o_A0, 1);
      rst = 1;
      #1 check_reset_outputs("rst_dpulse");
      #1 rst = 0;
      model_reset();
      #1 do_cycle(1, 1, 8'h3C, 8'hC3, 1, acc);
      chk("post_rst_acc", acc, 1);
      drain(1, 200, "drain_post_rst1");
      push_until_accepted(0, 8'h28, 8'h7E, "post_rst_acc0");
      drain(0, 600, "drain_post_rst0");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
